// File: rtl/fuzz_seq_pkg.sv
// Shared types, constants and helpers for the fuzz stimulus sequencer.
package fuzz_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam int          CNT_W     = 32;
  localparam int          POP_MAX_W = 64;

  // Counts set bits among the low 'width' bits of v (width <= POP_MAX_W).
  function automatic logic [6:0] popcount(input logic [POP_MAX_W-1:0] v, input int width);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      if (i < width) n = n + {6'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit left-shifting Galois LFSR with seed load and advance enable.
module lfsr32
  import fuzz_seq_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] value
);

  // An all-zero state would lock up the register, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

  // Seed on reset or load; otherwise step once per advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED_EFF;
    end else if (load) begin
      value <= SEED_EFF;
    end else if (adv) begin
      value <= {value[30:0], 1'b0} ^ (value[31] ? LFSR_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/fuzz_seq_ctrl.sv
// Clocked stimulus sequencer: drives pseudo-random vectors into a
// combinational DUT, waits a settle time, then tallies Z / non-Z output bits.
module fuzz_seq_ctrl
  import fuzz_seq_pkg::*;
#(
  parameter int          IN_WIDTH  = 8,
  parameter int          OUT_WIDTH = 8,
  parameter int          CYCLES    = 20,
  parameter int          SETTLE    = 1,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IN_WIDTH-1:0]  stim,
  input  logic [OUT_WIDTH-1:0] obs_flat,
  input  logic [OUT_WIDTH-1:0] obs_z,
  output logic                 busy,
  output logic                 done,
  output logic                 rec_valid,
  output logic [OUT_WIDTH-1:0] rec_out,
  output logic [15:0]          iter,
  output logic [CNT_W-1:0]     z_count,
  output logic [CNT_W-1:0]     normal_count
);

  localparam logic [15:0] LAST_ITER = (CYCLES > 0) ? 16'(CYCLES - 1) : 16'd0;

  state_t           state;
  logic [31:0]      settle_cnt;
  logic [31:0]      lfsr_val;
  logic             launch;
  logic [CNT_W-1:0] z_inc;
  logic [CNT_W-1:0] normal_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // A run may only begin from IDLE, or from DONE once done has been shown.
  always_comb begin
    launch     = start && ((state == ST_IDLE) || ((state == ST_DONE) && done));
    z_inc      = CNT_W'(popcount(POP_MAX_W'(obs_z), OUT_WIDTH));
    normal_inc = CNT_W'(OUT_WIDTH) - z_inc;
  end

  lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .adv   (state == ST_DRIVE),
    .value (lfsr_val)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      stim         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rec_valid    <= 1'b0;
      rec_out      <= '0;
      iter         <= '0;
      z_count      <= '0;
      normal_count <= '0;
      settle_cnt   <= '0;
    end else begin
      rec_valid <= 1'b0;
      if (launch) begin
        iter         <= '0;
        z_count      <= '0;
        normal_count <= '0;
        done         <= 1'b0;
        if (CYCLES == 0) begin
          state <= ST_DONE;
          busy  <= 1'b0;
        end else begin
          state <= ST_DRIVE;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          ST_DRIVE: begin
            stim       <= lfsr_val[IN_WIDTH-1:0];
            settle_cnt <= 32'(SETTLE);
            state      <= ST_SETTLE;
          end
          ST_SETTLE: begin
            settle_cnt <= settle_cnt - 32'd1;
            if (settle_cnt <= 32'd1) state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            z_count      <= sat_add(z_count, z_inc);
            normal_count <= sat_add(normal_count, normal_inc);
            rec_out      <= obs_flat;
            rec_valid    <= 1'b1;
            if (iter == LAST_ITER) begin
              state <= ST_DONE;
              busy  <= 1'b0;
            end else begin
              iter  <= iter + 16'd1;
              state <= ST_DRIVE;
            end
          end
          // done rises one edge after DONE is entered.
          ST_DONE: done <= 1'b1;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fuzz_seq_ctrl.sv
// Directed bench for fuzz_seq_ctrl: three instances cover CYCLES = 4, 20, 0.
module tb_fuzz_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // CYCLES=4 instance
  logic        start4;
  logic [7:0]  stim4, rec_out4;
  logic [7:0]  obs_flat4, obs_z4;
  logic        busy4, done4, rv4;
  logic [15:0] iter4;
  logic [31:0] z4, n4;

  // CYCLES=20 instance
  logic        start20;
  logic [7:0]  stim20, rec_out20;
  logic [7:0]  obs_flat20, obs_z20;
  logic        busy20, done20, rv20;
  logic [15:0] iter20;
  logic [31:0] z20, n20;

  // CYCLES=0 instance
  logic        start0;
  logic [7:0]  stim0, rec_out0;
  logic [7:0]  obs_flat0, obs_z0;
  logic        busy0, done0, rv0;
  logic [15:0] iter0;
  logic [31:0] z0, n0;

  fuzz_seq_ctrl #(.IN_WIDTH(8), .OUT_WIDTH(8), .CYCLES(4), .SETTLE(1), .SEED(32'h1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stim(stim4), .obs_flat(obs_flat4),
    .obs_z(obs_z4), .busy(busy4), .done(done4), .rec_valid(rv4), .rec_out(rec_out4),
    .iter(iter4), .z_count(z4), .normal_count(n4));

  fuzz_seq_ctrl #(.IN_WIDTH(8), .OUT_WIDTH(8), .CYCLES(20), .SETTLE(1), .SEED(32'h1)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .start(start20), .stim(stim20), .obs_flat(obs_flat20),
    .obs_z(obs_z20), .busy(busy20), .done(done20), .rec_valid(rv20), .rec_out(rec_out20),
    .iter(iter20), .z_count(z20), .normal_count(n20));

  fuzz_seq_ctrl #(.IN_WIDTH(8), .OUT_WIDTH(8), .CYCLES(0), .SETTLE(1), .SEED(32'h1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim(stim0), .obs_flat(obs_flat0),
    .obs_z(obs_z0), .busy(busy0), .done(done0), .rec_valid(rv0), .rec_out(rec_out0),
    .iter(iter0), .z_count(z0), .normal_count(n0));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_stim [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  int pulses;
  int cyc;

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; start20 = 1'b0; start0 = 1'b0;
    obs_flat4 = 8'hA5; obs_z4 = 8'h00;
    obs_flat20 = 8'h3C; obs_z20 = 8'h0F;
    obs_flat0 = 8'h00; obs_z0 = 8'h00;
    tick();
    tick();

    // Reset values
    check("rst_stim", 64'(stim4), 64'h0);
    check("rst_busy", 64'(busy4), 64'h0);
    check("rst_done", 64'(done4), 64'h0);
    check("rst_rv", 64'(rv4), 64'h0);
    check("rst_rec_out", 64'(rec_out4), 64'h0);
    check("rst_iter", 64'(iter4), 64'h0);
    check("rst_z", 64'(z4), 64'h0);
    check("rst_normal", 64'(n4), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Idle: no activity for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_rv", 64'(rv4), 64'h0);
    end
    check("idle_busy", 64'(busy4), 64'h0);

    // Run CYCLES=4, SETTLE=1, obs_z=0
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("run4_busy_e0", 64'(busy4), 64'h1);
    check("run4_stim_e0", 64'(stim4), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("run4_stim_drive", 64'(stim4), 64'(exp_stim[i]));
      check("run4_rv_drive", 64'(rv4), 64'h0);
      tick();
      check("run4_stim_settle", 64'(stim4), 64'(exp_stim[i]));
      tick();
      check("run4_rv_sample", 64'(rv4), 64'h1);
      check("run4_rec_out", 64'(rec_out4), 64'hA5);
      check("run4_iter", 64'(iter4), (i < 3) ? 64'(i + 1) : 64'd3);
      check("run4_normal_partial", 64'(n4), 64'(8 * (i + 1)));
    end
    check("run4_done_e12", 64'(done4), 64'h0);
    check("run4_busy_e12", 64'(busy4), 64'h0);
    tick();
    check("run4_done_e13", 64'(done4), 64'h1);
    check("run4_z", 64'(z4), 64'd0);
    check("run4_normal", 64'(n4), 64'd32);
    check("run4_iter_final", 64'(iter4), 64'd3);
    check("run4_stim_held", 64'(stim4), 64'h08);

    // Run CYCLES=20 with obs_z = 8'h0F
    start20 = 1'b1;
    tick();
    start20 = 1'b0;
    pulses = 0;
    cyc = 0;
    while (!done20 && cyc < 200) begin
      tick();
      cyc++;
      if (rv20) pulses++;
    end
    check("run20_done", 64'(done20), 64'h1);
    check("run20_done_edge", 64'(cyc), 64'd61);
    check("run20_pulses", 64'(pulses), 64'd20);
    check("run20_z", 64'(z20), 64'd80);
    check("run20_normal", 64'(n20), 64'd80);
    check("run20_iter", 64'(iter20), 64'd19);
    check("run20_rec_out", 64'(rec_out20), 64'h3C);

    // Run CYCLES=0
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("run0_done_e0", 64'(done0), 64'h0);
    tick();
    check("run0_done_e1", 64'(done0), 64'h1);
    check("run0_busy", 64'(busy0), 64'h0);
    check("run0_z", 64'(z0), 64'h0);
    check("run0_normal", 64'(n0), 64'h0);
    check("run0_stim", 64'(stim0), 64'h0);

    // Reset during SETTLE of iteration 2
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mid_stim_before", 64'(stim4), 64'h04);
    check("mid_normal_before", 64'(n4), 64'd16);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stim", 64'(stim4), 64'h0);
    check("mid_rst_busy", 64'(busy4), 64'h0);
    check("mid_rst_iter", 64'(iter4), 64'h0);
    check("mid_rst_normal", 64'(n4), 64'h0);
    check("mid_rst_done", 64'(done4), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    check("mid_restart_stim", 64'(stim4), 64'h01);
    for (int i = 0; i < 12; i++) tick();
    check("mid_restart_done", 64'(done4), 64'h1);
    check("mid_restart_normal", 64'(n4), 64'd32);

    // start held high for a whole run, then an automatic restart in DONE
    start4 = 1'b1;
    tick();
    check("hold_busy_e0", 64'(busy4), 64'h1);
    for (int i = 0; i < 10; i++) tick();
    check("hold_stim_e10", 64'(stim4), 64'h08);
    check("hold_iter_e10", 64'(iter4), 64'd3);
    tick();
    tick();
    check("hold_done_e12", 64'(done4), 64'h0);
    tick();
    check("hold_done_e13", 64'(done4), 64'h1);
    check("hold_normal_1", 64'(n4), 64'd32);
    check("hold_z_1", 64'(z4), 64'd0);
    tick();
    check("hold_restart_done", 64'(done4), 64'h0);
    check("hold_restart_busy", 64'(busy4), 64'h1);
    check("hold_restart_normal", 64'(n4), 64'd0);
    check("hold_restart_iter", 64'(iter4), 64'd0);
    tick();
    check("hold_run2_stim", 64'(stim4), 64'h01);
    for (int i = 0; i < 12; i++) tick();
    check("hold_run2_done", 64'(done4), 64'h1);
    check("hold_run2_normal", 64'(n4), 64'd32);
    check("hold_run2_z", 64'(z4), 64'd0);
    start4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fuzz_seq_ctrl.md
# fuzz_seq_ctrl

Clocked stimulus sequencer for the Z-handling fuzz experiments. It drives a combinational DUT's flat input bus with pseudo-random vectors for a fixed number of iterations. After a programmable settle time it samples the DUT's flat output plus a per-bit Z mask, and accumulates Z and non-Z bit counts. It replaces the delay-based `initial` loop, so the same experiment runs on a clock and can be synthesized or run under Verilator's timing-free mode.

## Interface
- IN_WIDTH, 8, DUT input width, 1..32
- OUT_WIDTH, 8, DUT output width, 1..64
- CYCLES, 20, iterations per run, 0..65535
- SETTLE, 1, settle cycles between drive and sample, ≥1
- SEED, 32'h0000_0001, LFSR seed; 0 is replaced by 1
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- stim  out  IN_WIDTH  DUT input vector (in_flat)
- obs_flat  in  OUT_WIDTH  DUT output (out_flat)
- obs_z  in  OUT_WIDTH  per-bit Z flag from the probe wrapper (1 = bit is Z)
- busy  out  1  run in progress
- done  out  1  run complete; level, held in DONE
- rec_valid  out  1  one-cycle pulse per sampled iteration
- rec_out  out  OUT_WIDTH  obs_flat captured at the sample; valid with rec_valid
- iter  out  16  index of the current or last-sampled iteration
- z_count  out  32  accumulated Z bits, saturating
- normal_count  out  32  accumulated non-Z bits, saturating

## Operation
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - Clear counters and iter.
  - Load the LFSR with SEED (0→1).
  - Go to DRIVE, or to DONE if CYCLES=0.
- DRIVE, one cycle:
  - stim ← lfsr[IN_WIDTH-1:0].
  - Advance the LFSR.
  - Load the settle counter with SETTLE.
  - Go to SETTLE.
- SETTLE: decrement the settle counter; go to SAMPLE after exactly SETTLE cycles.
- SAMPLE, one cycle:
  - z_count += popcount(obs_z).
  - normal_count += OUT_WIDTH − popcount(obs_z).
  - rec_out ← obs_flat; pulse rec_valid.
  - If iter == CYCLES−1, go to DONE; else iter++ and go to DRIVE.
- DONE:
  - done=1; counts, iter and stim are held.
  - start=1 restarts exactly as from IDLE, with counters cleared.
- start is ignored in DRIVE, SETTLE and SAMPLE.
- LFSR: 32-bit Galois, left shift, polynomial x^32+x^22+x^2+x+1.
  - next = {l[30:0],1'b0} ^ (l[31] ? 32'h0040_0007 : 0).
- Counters saturate at 32'hFFFF_FFFF.
- obs_flat bits that are X/Z do not affect the counts; only obs_z decides.

## Timing
- Reset values:
  - State IDLE.
  - stim=0, busy=0, done=0, rec_valid=0, rec_out=0.
  - iter=0, z_count=0, normal_count=0.
  - LFSR=SEED.
- busy=1 in DRIVE, SETTLE and SAMPLE.
- stim changes only on the DRIVE edge and is stable for SETTLE+1 cycles before the sample edge.
- Each iteration takes SETTLE+2 cycles.
- done rises CYCLES·(SETTLE+2)+1 edges after the edge that samples start.
- For CYCLES=0, done rises 1 edge after start.
- rec_valid is asserted in the cycle after the SAMPLE edge. Counters and iter update on the same edge.
- Reset mid-run is asynchronous: outputs take their reset values immediately and no partial counts survive.

## Structure
- Package fuzz_seq_pkg:
  - state enum.
  - LFSR_POLY = 32'h0040_0007.
  - Counter width constant (32).
  - popcount function, parameterized by width.
- Sub-module lfsr32 (seed load, advance enable, 32-bit state output) instantiated once.
- The Z-detect wrapper that produces obs_z is outside this block.

## Test plan
- Reset → all outputs 0 and state IDLE; no rec_valid pulse over 10 idle cycles.
- Run with CYCLES=4, SETTLE=1, SEED=1, obs_z=0:
  - stim = 8'h01, 8'h02, 8'h04, 8'h08.
  - z_count=0, normal_count=32.
  - done at edge 13.
- Run with CYCLES=20, obs_z=8'h0F constant → z_count=80, normal_count=80, iter=19, 20 rec_valid pulses.
- Run with CYCLES=0 → done=1 one edge after start; counts 0; stim stays 0.
- rst_n dropped during SETTLE of iteration 2:
  - Outputs reset immediately.
  - A new start reproduces the first-run stim sequence from 8'h01.
- start held high for a whole run:
  - No restart while busy.
  - In DONE it restarts with counters cleared; the second run's totals equal the first run's.
